// File: rtl/dna_pkg.sv
// Shared types and modular-arithmetic helpers for the DNA single-deletion repair path.
package dna_pkg;

  typedef logic [1:0] digit_t;

  typedef enum logic [1:0] {
    COLLECT,
    SEARCH,
    OUTPUT
  } state_t;

  // Index width shared with the digit-insertion stage.
  localparam int unsigned IDX_W = 7;

  // Container width for weighted-checksum values; every value held in it is < WMOD.
  localparam int unsigned ACC_W = 16;
  typedef logic [ACC_W-1:0] acc_t;

  function automatic digit_t add_mod4(input digit_t a, input digit_t b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd4) s = s - 3'd4;
    return s[1:0];
  endfunction

  // Operands must already be reduced (a < m, b < m).
  function automatic acc_t add_modw(input acc_t a, input acc_t b, input acc_t m);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[ACC_W-1:0];
  endfunction

  // a*d mod m for a digit multiplier, built from reduced additions so nothing wraps.
  function automatic acc_t mul_digit_modw(input acc_t a, input digit_t d, input acc_t m);
    acc_t a2;
    acc_t t;
    a2 = add_modw(a, a, m);
    t  = d[1] ? a2 : '0;
    if (d[0]) t = add_modw(t, a, m);
    return t;
  endfunction

endpackage

// File: rtl/deletion_locator_wsum_search.sv
// SEARCH datapath: suffix accumulator, weighted-checksum candidate compare and match register.
module wsum_search
  import dna_pkg::*;
#(
  parameter int unsigned N       = 6,
  parameter int unsigned WMOD    = 4 * N,
  parameter int unsigned WTARGET = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic [IDX_W-1:0] p,
  input  digit_t           r_p,
  input  acc_t             wsum,
  input  digit_t           mdig,
  output logic             found,
  output logic [IDX_W-1:0] match_idx
);

  localparam acc_t MODW   = acc_t'(WMOD);
  localparam acc_t TARGET = acc_t'(WTARGET);

  acc_t suffix_q;
  acc_t suffix_d;
  acc_t cand;
  logic has_digit;

  // Candidate p inserts mdig at p: digits at or right of p gain weight 1, hence + suffix.
  always_comb begin
    has_digit = (p <= IDX_W'(N - 2));
    suffix_d  = has_digit ? add_modw(suffix_q, acc_t'(r_p), MODW) : suffix_q;
    cand      = add_modw(add_modw(wsum, mul_digit_modw(acc_t'(p), mdig, MODW), MODW),
                         suffix_d, MODW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      suffix_q  <= '0;
      found     <= 1'b0;
      match_idx <= '0;
    end else if (clear) begin
      suffix_q  <= '0;
      found     <= 1'b0;
      match_idx <= '0;
    end else if (step) begin
      suffix_q <= suffix_d;
      if (cand == TARGET) begin
        found     <= 1'b1;
        match_idx <= p;
      end
    end
  end

endmodule

// File: rtl/deletion_locator.sv
// Single-deletion locator: collects N-1 quaternary digits, finds the deleted digit and position.
// Optional macro ERR_COUNT_EN adds a saturating err_count output.
module deletion_locator
  import dna_pkg::*;
#(
  parameter int unsigned N       = 6,
  parameter int unsigned WMOD    = 4 * N,
  parameter int unsigned WTARGET = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_digit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*(N-1)-1:0] word_out,
  output logic [IDX_W-1:0]   missing_index_ltr,
  output logic [1:0]         missing_digit,
  output logic               err
`ifdef ERR_COUNT_EN
  ,
  output logic [15:0]        err_count
`endif
);

  localparam int unsigned WW       = 2 * (N - 1);
  localparam int unsigned LAST_CNT = N - 2;
  localparam acc_t        MODW     = acc_t'(WMOD);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] count_q;
  logic [IDX_W-1:0] p_q;
  digit_t           digit_sum_q;
  digit_t           sum_next;
  digit_t           mdig_q;
  acc_t             wsum_q;
  logic [WW-1:0]    word_q;
  digit_t           r_p;
  logic             accept;
  logic             handshake;
  logic             last_accept;
  logic             found;
  logic [IDX_W-1:0] match_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && count_q == IDX_W'(LAST_CNT)) state_d = SEARCH;
      end
      SEARCH: begin
        if (p_q == '0) state_d = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  assign accept      = in_valid && in_ready;
  assign handshake   = out_valid && out_ready;
  assign last_accept = accept && (count_q == IDX_W'(LAST_CNT));
  assign sum_next    = add_mod4(digit_sum_q, in_digit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      p_q         <= '0;
      digit_sum_q <= '0;
      mdig_q      <= '0;
      wsum_q      <= '0;
      word_q      <= '0;
    end else if (handshake) begin
      count_q     <= '0;
      p_q         <= '0;
      digit_sum_q <= '0;
      mdig_q      <= '0;
      wsum_q      <= '0;
      word_q      <= '0;
    end else if (accept) begin
      word_q      <= {word_q[WW-3:0], in_digit};
      digit_sum_q <= sum_next;
      wsum_q      <= add_modw(wsum_q, mul_digit_modw(acc_t'(count_q), in_digit, MODW), MODW);
      count_q     <= count_q + IDX_W'(1);
      // Missing digit fixed at the final accept so it is valid for the whole search.
      if (last_accept) begin
        mdig_q <= add_mod4(~sum_next, 2'd1);
        p_q    <= IDX_W'(N - 1);
      end
    end else if (state_q == SEARCH && p_q != '0) begin
      p_q <= p_q - IDX_W'(1);
    end
  end

  // Received digit at ltr position p (digit 0 sits in the MSBs).
  always_comb begin
    r_p = '0;
    for (int unsigned i = 0; i < N - 1; i++) begin
      if (p_q == IDX_W'(i)) r_p = word_q[2*(N-2-i) +: 2];
    end
  end

  wsum_search #(
    .N       (N),
    .WMOD    (WMOD),
    .WTARGET (WTARGET)
  ) u_search (
    .clk       (clk),
    .rst       (rst),
    .clear     (handshake),
    .step      (state_q == SEARCH),
    .p         (p_q),
    .r_p       (r_p),
    .wsum      (wsum_q),
    .mdig      (mdig_q),
    .found     (found),
    .match_idx (match_idx)
  );

  assign word_out          = word_q;
  assign missing_digit     = mdig_q;
  assign missing_index_ltr = found ? match_idx : '0;
  assign err               = out_valid && !found;

`ifdef ERR_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        err_count <= '0;
    else if (handshake && err && err_count != '1)   err_count <= err_count + 16'd1;
  end
`endif

endmodule
